// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Parses 6-byte command frames arriving as a byte stream from a UART
//   receiver. The frame layout is:
//     0xA5, ADDR, D2, D1, D0, CSUM
//   where CSUM = ADDR ^ D2 ^ D1 ^ D0.
//
//   ADDR 0x00 writes the 24-bit tuning word {D2,D1,D0}.
//   ADDR 0x01 writes the gain byte D0.
//   A bad checksum, an unknown address, or an over-long gap inside a frame
//   drops the frame and raises an error pulse with a cause code.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous, active-high reset
//   data_i     : received UART byte
//   valid_i    : one-cycle strobe, data_i is valid this cycle
//   ftw_o      : NCO frequency tuning word (registered)
//   gain_o     : demodulator output gain (registered)
//   update_o   : one-cycle pulse, ftw_o or gain_o was just written
//   err_o      : one-cycle pulse, a frame was dropped
//   err_code_o : cause of the most recent error
//                (0 none, 1 checksum, 2 timeout, 3 bad address)
//   busy_o     : high while a frame is partially received
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT  = 1024,
   parameter logic [23:0] FTW_RST  = 24'd0,
   parameter logic [7:0]  GAIN_RST = 8'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data_i,
   input  logic        valid_i,
   output logic [23:0] ftw_o,
   output logic [7:0]  gain_o,
   output logic        update_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      S_HUNT = 3'd0,
      S_ADDR = 3'd1,
      S_D2   = 3'd2,
      S_D1   = 3'd3,
      S_D0   = 3'd4,
      S_CSUM = 3'd5
   } state_t;

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   localparam logic [7:0]  ADDR_FTW  = 8'h00;
   localparam logic [7:0]  ADDR_GAIN = 8'h01;
   // The idle cycle on which the counter already holds TIMEOUT-1 is the
   // TIMEOUT-th consecutive idle cycle; that is where the frame is dropped.
   localparam logic [15:0] GAP_LIMIT = 16'(TIMEOUT - 32'd1);

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_CSUM  = 2'd1;
   localparam logic [1:0] ERR_TOUT  = 2'd2;
   localparam logic [1:0] ERR_ADDR  = 2'd3;

   // XOR checksum over the four covered frame bytes.
   function automatic logic [7:0] frame_csum(
      input logic [7:0] addr,
      input logic [7:0] d2,
      input logic [7:0] d1,
      input logic [7:0] d0
   );
      return addr ^ d2 ^ d1 ^ d0;
   endfunction

   state_t      state_r, state_s;
   logic [15:0] gap_r, gap_s;
   logic [7:0]  addr_r, addr_s;
   logic [7:0]  d2_r, d2_s;
   logic [7:0]  d1_r, d1_s;
   logic [7:0]  d0_r, d0_s;
   logic [23:0] ftw_r, ftw_s;
   logic [7:0]  gain_r, gain_s;
   logic        update_r, update_s;
   logic        err_r, err_s;
   logic [1:0]  code_r, code_s;
   logic        busy_r, busy_s;

   // State register of the frame FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_HUNT;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, shadow capture, gap counting and next output values.
   always_comb begin
      state_s  = state_r;
      gap_s    = gap_r;
      addr_s   = addr_r;
      d2_s     = d2_r;
      d1_s     = d1_r;
      d0_s     = d0_r;
      ftw_s    = ftw_r;
      gain_s   = gain_r;
      update_s = 1'b0;
      err_s    = 1'b0;
      code_s   = code_r;

      if (valid_i) begin
         // Any accepted byte restarts the inter-byte gap measurement,
         // including a byte arriving on the cycle a timeout would fire.
         gap_s = 16'd0;
         case (state_r)
            S_HUNT: begin
               if (data_i == SYNC_BYTE) begin
                  state_s = S_ADDR;
               end else begin
                  state_s = S_HUNT;
               end
            end
            S_ADDR: begin
               addr_s  = data_i;
               state_s = S_D2;
            end
            S_D2: begin
               d2_s    = data_i;
               state_s = S_D1;
            end
            S_D1: begin
               d1_s    = data_i;
               state_s = S_D0;
            end
            S_D0: begin
               d0_s    = data_i;
               state_s = S_CSUM;
            end
            S_CSUM: begin
               state_s = S_HUNT;
               // Checksum is judged before the address is decoded.
               if (data_i != frame_csum(addr_r, d2_r, d1_r, d0_r)) begin
                  err_s  = 1'b1;
                  code_s = ERR_CSUM;
               end else if (addr_r == ADDR_FTW) begin
                  ftw_s    = {d2_r, d1_r, d0_r};
                  update_s = 1'b1;
               end else if (addr_r == ADDR_GAIN) begin
                  gain_s   = d0_r;
                  update_s = 1'b1;
               end else begin
                  err_s  = 1'b1;
                  code_s = ERR_ADDR;
               end
            end
            default: begin
               state_s = S_HUNT;
            end
         endcase
      end else if (state_r != S_HUNT) begin
         if (gap_r == GAP_LIMIT) begin
            state_s = S_HUNT;
            gap_s   = 16'd0;
            addr_s  = 8'd0;
            d2_s    = 8'd0;
            d1_s    = 8'd0;
            d0_s    = 8'd0;
            err_s   = 1'b1;
            code_s  = ERR_TOUT;
         end else begin
            gap_s = gap_r + 16'd1;
         end
      end else begin
         gap_s = 16'd0;
      end

      busy_s = (state_s != S_HUNT);
   end

   // Shadow registers, gap counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_r    <= 16'd0;
         addr_r   <= 8'd0;
         d2_r     <= 8'd0;
         d1_r     <= 8'd0;
         d0_r     <= 8'd0;
         ftw_r    <= FTW_RST;
         gain_r   <= GAIN_RST;
         update_r <= 1'b0;
         err_r    <= 1'b0;
         code_r   <= ERR_NONE;
         busy_r   <= 1'b0;
      end else begin
         gap_r    <= gap_s;
         addr_r   <= addr_s;
         d2_r     <= d2_s;
         d1_r     <= d1_s;
         d0_r     <= d0_s;
         ftw_r    <= ftw_s;
         gain_r   <= gain_s;
         update_r <= update_s;
         err_r    <= err_s;
         code_r   <= code_s;
         busy_r   <= busy_s;
      end
   end

   assign ftw_o      = ftw_r;
   assign gain_o     = gain_r;
   assign update_o   = update_r;
   assign err_o      = err_r;
   assign err_code_o = code_r;
   assign busy_o     = busy_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Directed frames followed by randomized frame traffic, compared every
//   cycle against a byte-queue reference model of the frame rules.
module tb_uart_cmd_parser;

   localparam int unsigned TOUT     = 16;
   localparam logic [23:0] FTW_INIT = 24'h000123;
   localparam logic [7:0]  GAIN_INIT = 8'd1;

   logic        clk;
   logic        rst;
   logic [7:0]  data_i;
   logic        valid_i;
   logic [23:0] ftw_o;
   logic [7:0]  gain_o;
   logic        update_o;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic        busy_o;

   int checks;
   int errors;

   // Reference model state: the bytes of the frame collected so far.
   logic [7:0]  frame_q[$];
   int          idle_cnt;
   logic [23:0] exp_ftw;
   logic [7:0]  exp_gain;
   logic        exp_upd;
   logic        exp_err;
   logic [1:0]  exp_code;
   logic        exp_busy;

   uart_cmd_parser #(
      .TIMEOUT (TOUT),
      .FTW_RST (FTW_INIT),
      .GAIN_RST(GAIN_INIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data_i    (data_i),
      .valid_i   (valid_i),
      .ftw_o     (ftw_o),
      .gain_o    (gain_o),
      .update_o  (update_o),
      .err_o     (err_o),
      .err_code_o(err_code_o),
      .busy_o    (busy_o)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      frame_q.delete();
      idle_cnt = 0;
      exp_ftw  = FTW_INIT;
      exp_gain = GAIN_INIT;
      exp_upd  = 1'b0;
      exp_err  = 1'b0;
      exp_code = 2'd0;
      exp_busy = 1'b0;
   endtask

   // Judge a complete six-byte frame.
   task automatic model_frame();
      if (frame_q[5] != (frame_q[1] ^ frame_q[2] ^ frame_q[3] ^ frame_q[4])) begin
         exp_err  = 1'b1;
         exp_code = 2'd1;
      end else if (frame_q[1] == 8'h00) begin
         exp_ftw = {frame_q[2], frame_q[3], frame_q[4]};
         exp_upd = 1'b1;
      end else if (frame_q[1] == 8'h01) begin
         exp_gain = frame_q[4];
         exp_upd  = 1'b1;
      end else begin
         exp_err  = 1'b1;
         exp_code = 2'd3;
      end
   endtask

   // Advance the model by one clock with the given input.
   task automatic model_step(input logic v, input logic [7:0] d);
      exp_upd = 1'b0;
      exp_err = 1'b0;
      if (v) begin
         idle_cnt = 0;
         if (frame_q.size() == 0) begin
            if (d == 8'hA5) frame_q.push_back(d);
         end else begin
            frame_q.push_back(d);
            if (frame_q.size() == 6) begin
               model_frame();
               frame_q.delete();
            end
         end
      end else if (frame_q.size() != 0) begin
         idle_cnt++;
         if (idle_cnt == TOUT) begin
            exp_err  = 1'b1;
            exp_code = 2'd2;
            frame_q.delete();
            idle_cnt = 0;
         end
      end
      exp_busy = (frame_q.size() != 0);
   endtask

   task automatic compare_all();
      check_eq("ftw",    {8'd0, ftw_o},       {8'd0, exp_ftw});
      check_eq("gain",   {24'd0, gain_o},     {24'd0, exp_gain});
      check_eq("update", {31'd0, update_o},   {31'd0, exp_upd});
      check_eq("err",    {31'd0, err_o},      {31'd0, exp_err});
      check_eq("code",   {30'd0, err_code_o}, {30'd0, exp_code});
      check_eq("busy",   {31'd0, busy_o},     {31'd0, exp_busy});
   endtask

   // One clock: drive, let the edge happen, then compare.
   task automatic cycle(input logic v, input logic [7:0] d);
      valid_i = v;
      data_i  = d;
      @(posedge clk);
      #1;
      model_step(v, d);
      compare_all();
      valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
   endtask

   task automatic send6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
      cycle(1'b1, b0);
      cycle(1'b1, b1);
      cycle(1'b1, b2);
      cycle(1'b1, b3);
      cycle(1'b1, b4);
      cycle(1'b1, b5);
   endtask

   // Asynchronous reset with valid bytes offered while it is held.
   task automatic do_reset();
      rst     = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'hA5;
      #1;
      model_reset();
      compare_all();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst     = 1'b0;
      valid_i = 1'b0;
   endtask

   initial begin
      logic [7:0] fb[6];
      logic [7:0] junk;
      int gap;
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      valid_i = 1'b0;
      data_i  = 8'h00;
      model_reset();
      #12;
      compare_all();
      rst = 1'b0;
      idle(2);

      // Tuning word write, gain write, bad checksum then recovery.
      send6(8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h70);
      idle(1);
      send6(8'hA5, 8'h01, 8'h00, 8'h00, 8'h80, 8'h81);
      send6(8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h71);
      send6(8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00);
      // Timeout, then a stray byte seen in HUNT.
      cycle(1'b1, 8'hA5);
      cycle(1'b1, 8'h00);
      cycle(1'b1, 8'h12);
      idle(TOUT);
      cycle(1'b1, 8'h34);
      idle(2);
      // Gap one short of the timeout keeps the frame alive.
      cycle(1'b1, 8'hA5);
      cycle(1'b1, 8'h01);
      idle(TOUT - 1);
      cycle(1'b1, 8'h00);
      cycle(1'b1, 8'h00);
      cycle(1'b1, 8'h42);
      cycle(1'b1, 8'h43);
      // Junk before sync, then an unknown address.
      cycle(1'b1, 8'h00);
      cycle(1'b1, 8'hFF);
      send6(8'hA5, 8'h07, 8'h01, 8'h02, 8'h03, 8'h07);
      // Reset in the middle of a frame.
      cycle(1'b1, 8'hA5);
      cycle(1'b1, 8'h00);
      cycle(1'b1, 8'h12);
      do_reset();
      idle(1);
      send6(8'hA5, 8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h89);
      idle(1);

      // Randomized traffic.
      for (int f = 0; f < 300; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            cycle(1'b1, junk);
         end
         fb[0] = 8'hA5;
         case ($urandom_range(0, 3))
            0:       fb[1] = 8'h00;
            1:       fb[1] = 8'h01;
            2:       fb[1] = 8'hA5;
            default: fb[1] = 8'($urandom_range(0, 255));
         endcase
         fb[2] = 8'($urandom_range(0, 255));
         fb[3] = 8'($urandom_range(0, 255));
         fb[4] = 8'($urandom_range(0, 255));
         fb[5] = fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
         if ($urandom_range(0, 4) == 0) fb[5] = fb[5] ^ 8'($urandom_range(1, 255));
         for (int b = 0; b < 6; b++) begin
            if (b != 0) begin
               case ($urandom_range(0, 19))
                  0:       gap = TOUT - 1;
                  1:       gap = TOUT;
                  2, 3, 4: gap = $urandom_range(1, 3);
                  default: gap = 0;
               endcase
               idle(gap);
            end
            if (b == 3 && $urandom_range(0, 39) == 0) do_reset();
            cycle(1'b1, fb[b]);
         end
      end
      idle(TOUT + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: TIMEOUT, 1024, max idle clk cycles between bytes of one frame; range 2..65535.
REQ-002 Parameter: FTW_RST, 24'd0, reset value of ftw_o.
REQ-003 Parameter: GAIN_RST, 8'd1, reset value of gain_o.
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: data_i  input  8  received UART byte.
REQ-007 Port: valid_i  input  1  one-cycle strobe; data_i valid this cycle.
REQ-008 Port: ftw_o  output  24  NCO frequency tuning word.
REQ-009 Port: gain_o  output  8  demodulator output gain.
REQ-010 Port: update_o  output  1  one-cycle pulse: ftw_o or gain_o just written.
REQ-011 Port: err_o  output  1  one-cycle pulse: frame dropped.
REQ-012 Port: err_code_o  output  2  cause of last error: 0 none, 1 checksum, 2 timeout, 3 bad address.
REQ-013 Port: busy_o  output  1  high while a frame is partially received (state != HUNT).

Function
REQ-014 Frame = 6 bytes: SYNC 0xA5, ADDR, D2, D1, D0 (24-bit payload, MSB first), CSUM.
REQ-015 CSUM SHALL equal ADDR ^ D2 ^ D1 ^ D0.
REQ-016 FSM states: HUNT, ADDR, D2, D1, D0, CSUM; state advances only on cycles with valid_i=1.
REQ-017 HUNT: valid_i with data_i=0xA5 -> ADDR; any other byte ignored, no error.
REQ-018 ADDR, D2, D1, D0: byte captured into shadow register, advance to next state; 0xA5 inside frame is ordinary data (no resync).
REQ-019 CSUM: byte compared; always return to HUNT.
REQ-020 Checksum match, ADDR=0x00: ftw_o <= {D2,D1,D0}; update_o=1 next cycle.
REQ-021 Checksum match, ADDR=0x01: gain_o <= D0 (D2, D1 ignored); update_o=1 next cycle.
REQ-022 Checksum match, other ADDR: outputs unchanged; err_o=1, err_code_o=3.
REQ-023 Checksum mismatch: outputs unchanged; err_o=1, err_code_o=1 (checksum checked before address).
REQ-024 ftw_o, gain_o, update_o, err_o, err_code_o, busy_o SHALL be registered; latency from CSUM strobe cycle to output change/pulse = 1 clk.
REQ-025 Gap counter: cleared on every valid_i; increments each cycle with state != HUNT and valid_i=0; held at 0 in HUNT; width 16 bits.
REQ-026 Counter reaching TIMEOUT-1 with valid_i=0 -> HUNT, shadow cleared, err_o=1, err_code_o=2 next cycle.
REQ-027 valid_i in the cycle the timeout would fire: byte accepted, no timeout.
REQ-028 err_code_o holds last cause until next error or reset; successful frame does not clear it.
REQ-029 update_o and err_o never asserted together; each pulse exactly 1 cycle.
REQ-030 Back-to-back frames with zero idle cycles between bytes and between frames SHALL be accepted without loss.
REQ-031 valid_i while rst=1 ignored.

Reset
REQ-032 rst=1 asynchronously forces: state HUNT, gap counter 0, shadow regs 0, ftw_o=FTW_RST, gain_o=GAIN_RST, update_o=0, err_o=0, err_code_o=0, busy_o=0.
REQ-033 Reset mid-frame discards partial frame with no err_o pulse; first frame after deassertion parsed normally.

Verification
REQ-034 Frame A5 00 12 34 56 70 -> ftw_o=0x123456, update_o one pulse 1 clk after CSUM strobe, err_o=0.
REQ-035 Frame A5 01 00 00 80 81 -> gain_o=0x80, ftw_o unchanged, update_o one pulse.
REQ-036 Frame A5 00 12 34 56 71 -> err_o pulse, err_code_o=1, ftw_o unchanged; following valid frame accepted.
REQ-037 Bytes A5 00 12 then TIMEOUT idle cycles -> err_o pulse, err_code_o=2, busy_o=0; next byte 0x34 ignored (HUNT).
REQ-038 Frame A5 07 01 02 03 07 -> err_o pulse, err_code_o=3; junk bytes 00 FF before SYNC produce no err_o.
REQ-039 rst asserted after A5 00 12, deasserted, then A5 00 AB CD EF 89 -> outputs at reset values until update, then ftw_o=0xABCDEF, no err_o.
